// File: rtl/fc_forward_stream.sv
// Fully-connected forward layer: y[j] = sat(relu?(sum_i x[i]*W[j][i] + b[j])).
// Operands are fetched through 1-cycle synchronous read ports; results stream out one neuron at a time.
module fc_forward_stream #(
  parameter int IN_SIZE  = 120,
  parameter int OUT_SIZE = 10,
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int ACC_W    = 40,
  localparam int IN_AW   = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1,
  localparam int W_AW    = (IN_SIZE * OUT_SIZE > 1) ? $clog2(IN_SIZE * OUT_SIZE) : 1,
  localparam int OUT_AW  = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              relu_en,
  output logic              busy,
  output logic              done,
  output logic              sat_flag,
  output logic [IN_AW-1:0]  in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic [W_AW-1:0]   w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [OUT_AW-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              out_valid,
  output logic [OUT_AW-1:0] out_idx,
  output logic [DATA_W-1:0] out_data
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_MAC    = 3'd1;
  localparam logic [2:0] S_DRAIN1 = 3'd2;
  localparam logic [2:0] S_DRAIN2 = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_FIN    = 3'd5;

  localparam logic [IN_AW-1:0]  I_LAST = IN_AW'(IN_SIZE - 1);
  localparam logic [OUT_AW-1:0] J_LAST = OUT_AW'(OUT_SIZE - 1);

  localparam logic signed [ACC_W-1:0] OUT_MAX =
    {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN =
    {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  logic [2:0] state;
  logic       relu_q;

  // Pipeline tags: rd_* marks read data arriving this cycle, prod_* marks a valid product.
  logic rd_vld, rd_first;
  logic prod_vld, prod_first;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc;

  logic signed [2*DATA_W-1:0] x_ext, w_ext;
  logic signed [ACC_W-1:0]    bias_ext, prod_ext, shifted, relu_val;
  logic [DATA_W-1:0]          sat_data;
  logic                       clipped;

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    x_ext    = $signed({{DATA_W{in_data[DATA_W-1]}}, in_data});
    w_ext    = $signed({{DATA_W{w_data[DATA_W-1]}}, w_data});
    bias_ext = $signed({{(ACC_W - DATA_W){b_data[DATA_W-1]}}, b_data}) <<< FRAC_W;
    prod_ext = $signed({{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod});

    // Arithmetic shift floors toward minus infinity; no rounding is applied.
    shifted  = acc >>> FRAC_W;
    relu_val = (relu_q && shifted[ACC_W-1]) ? '0 : shifted;

    sat_data = relu_val[DATA_W-1:0];
    clipped  = 1'b0;
    if (relu_val > OUT_MAX) begin
      sat_data = {1'b0, {(DATA_W - 1){1'b1}}};
      clipped  = 1'b1;
    end else if (relu_val < OUT_MIN) begin
      sat_data = {1'b1, {(DATA_W - 1){1'b0}}};
      clipped  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      relu_q     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sat_flag   <= 1'b0;
      in_addr    <= '0;
      w_addr     <= '0;
      b_addr     <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_data   <= '0;
      rd_vld     <= 1'b0;
      rd_first   <= 1'b0;
      prod_vld   <= 1'b0;
      prod_first <= 1'b0;
      prod       <= '0;
      acc        <= '0;
    end else begin
      out_valid  <= 1'b0;
      done       <= 1'b0;

      rd_vld     <= (state == S_MAC);
      rd_first   <= (state == S_MAC) && (in_addr == '0);
      prod_vld   <= rd_vld;
      prod_first <= rd_first;

      if (rd_vld) begin
        prod <= x_ext * w_ext;
      end

      // The first product of each neuron seeds the accumulator with the aligned bias.
      if (prod_vld) begin
        acc <= prod_first ? (bias_ext + prod_ext) : (acc + prod_ext);
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_MAC;
            busy     <= 1'b1;
            sat_flag <= 1'b0;
            relu_q   <= relu_en;
            in_addr  <= '0;
            w_addr   <= '0;
            b_addr   <= '0;
          end
        end

        S_MAC: begin
          if (in_addr == I_LAST) begin
            state <= S_DRAIN1;
          end else begin
            in_addr <= in_addr + 1'b1;
            w_addr  <= w_addr + 1'b1;
          end
        end

        S_DRAIN1: state <= S_DRAIN2;

        S_DRAIN2: state <= S_WRITE;

        S_WRITE: begin
          out_valid <= 1'b1;
          out_idx   <= b_addr;
          out_data  <= sat_data;
          if (clipped) begin
            sat_flag <= 1'b1;
          end
          if (b_addr == J_LAST) begin
            state <= S_FIN;
          end else begin
            state   <= S_MAC;
            b_addr  <= b_addr + 1'b1;
            in_addr <= '0;
            w_addr  <= w_addr + 1'b1;
          end
        end

        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_forward_stream.sv
// Directed bench for fc_forward_stream with IN_SIZE=4, OUT_SIZE=2, Q8.8 operands.
// Operand memories are modelled with 1-cycle read latency.
module tb_fc_forward_stream;

  localparam int IN_SIZE  = 4;
  localparam int OUT_SIZE = 2;
  localparam int DATA_W   = 16;
  localparam int MAX_CYC  = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        relu_en;
  logic        busy, done, sat_flag;
  logic [1:0]  in_addr;
  logic [15:0] in_data;
  logic [2:0]  w_addr;
  logic [15:0] w_data;
  logic [0:0]  b_addr;
  logic [15:0] b_data;
  logic        out_valid;
  logic [0:0]  out_idx;
  logic [15:0] out_data;

  fc_forward_stream #(
    .IN_SIZE (IN_SIZE),
    .OUT_SIZE(OUT_SIZE),
    .DATA_W  (DATA_W),
    .FRAC_W  (8),
    .ACC_W   (40)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .relu_en  (relu_en),
    .busy     (busy),
    .done     (done),
    .sat_flag (sat_flag),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .out_valid(out_valid),
    .out_idx  (out_idx),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  logic [15:0] x_mem [IN_SIZE];
  logic [15:0] w_mem [IN_SIZE*OUT_SIZE];
  logic [15:0] b_mem [OUT_SIZE];

  always @(posedge clk) begin
    in_data <= x_mem[in_addr];
    w_data  <= w_mem[w_addr];
    b_data  <= b_mem[b_addr];
  end

  typedef struct {
    logic [15:0] x0, xr, w0, wr, b0, b1;
    logic        relu;
    logic [15:0] exp0, exp1;
    logic        exp_sat;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // Observations collected by run_layer.
  int          n_valid, done_cyc;
  int          vcyc [2];
  logic [0:0]  vidx [2];
  logic [15:0] vdat [2];
  logic [1:0]  tr_in [20];
  logic [2:0]  tr_w  [20];
  logic [0:0]  tr_b  [20];
  logic        busy_at0, sat_at0, done_after, busy_after;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < IN_SIZE; i++) begin
      x_mem[i] = (i == 0) ? v.x0 : v.xr;
      for (int j = 0; j < OUT_SIZE; j++) begin
        w_mem[j*IN_SIZE + i] = (i == 0) ? v.w0 : v.wr;
      end
    end
    b_mem[0] = v.b0;
    b_mem[1] = v.b1;
  endtask

  // Cycle n is the interval following the n-th rising edge after the accept edge.
  task automatic run_layer(input logic relu, input bit mid_start);
    int cyc;
    bit got_done;
    n_valid  = 0;
    done_cyc = -1;
    got_done = 1'b0;
    @(posedge clk); #1;
    start   = 1'b1;
    relu_en = relu;
    @(posedge clk); #1;
    start   = 1'b0;
    relu_en = ~relu;
    cyc = 0;
    while (!got_done && cyc < MAX_CYC) begin
      @(negedge clk);
      if (cyc == 0) begin
        busy_at0 = busy;
        sat_at0  = sat_flag;
      end
      if (cyc < 20) begin
        tr_in[cyc] = in_addr;
        tr_w[cyc]  = w_addr;
        tr_b[cyc]  = b_addr;
      end
      if (out_valid) begin
        if (n_valid < 2) begin
          vcyc[n_valid] = cyc;
          vidx[n_valid] = out_idx;
          vdat[n_valid] = out_data;
        end
        n_valid++;
      end
      if (done) begin
        done_cyc = cyc;
        got_done = 1'b1;
      end
      if (mid_start) begin
        if (cyc == 5 || cyc == 13) start = 1'b1;
        else start = 1'b0;
      end
      if (!got_done) begin
        @(posedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(got_done), 32'd1);
    @(negedge clk);
    done_after = done;
    busy_after = busy;
  endtask

  vec_t vecs [9];
  int   quiet;

  initial begin
    vecs[0] = '{16'h0100, 16'h0100, 16'h0080, 16'h0080, 16'h0040, 16'h0040, 1'b0, 16'h0240, 16'h0240, 1'b0};
    vecs[1] = '{16'h0100, 16'h0100, 16'h0080, 16'h0080, 16'h0040, 16'hFF00, 1'b0, 16'h0240, 16'h0100, 1'b0};
    vecs[2] = '{16'h0100, 16'h0100, 16'hFF80, 16'hFF80, 16'h0040, 16'h0040, 1'b0, 16'hFE40, 16'hFE40, 1'b0};
    vecs[3] = '{16'h0100, 16'h0100, 16'hFF80, 16'hFF80, 16'h0040, 16'h0040, 1'b1, 16'h0000, 16'h0000, 1'b0};
    vecs[4] = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[5] = '{16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[6] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 1'b0, 16'h7FFF, 16'h7FFF, 1'b1};
    vecs[7] = '{16'h7FFF, 16'h7FFF, 16'h8001, 16'h8001, 16'h0000, 16'h0000, 1'b0, 16'h8000, 16'h8000, 1'b1};
    vecs[8] = '{16'h0100, 16'h0100, 16'h0080, 16'h0080, 16'h0040, 16'h0040, 1'b1, 16'h0240, 16'h0240, 1'b0};

    rst = 1'b0; start = 1'b0; relu_en = 1'b0;
    load_vec(vecs[0]);
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {28'd0, busy, done, sat_flag, out_valid}, 32'd0);
    check("reset_addr", {24'd0, in_addr, w_addr, b_addr, out_idx, 1'b0}, 32'd0);
    check("reset_data", 32'(out_data), 32'd0);
    rst = 1'b1;

    // Table-driven functional vectors.
    for (int k = 0; k < 9; k++) begin
      load_vec(vecs[k]);
      run_layer(vecs[k].relu, 1'b0);
      check($sformatf("v%0d_nvalid", k), 32'(n_valid), 32'd2);
      check($sformatf("v%0d_idx0", k), 32'(vidx[0]), 32'd0);
      check($sformatf("v%0d_out0", k), 32'(vdat[0]), 32'(vecs[k].exp0));
      check($sformatf("v%0d_idx1", k), 32'(vidx[1]), 32'd1);
      check($sformatf("v%0d_out1", k), 32'(vdat[1]), 32'(vecs[k].exp1));
      check($sformatf("v%0d_sat", k), 32'(sat_flag), 32'(vecs[k].exp_sat));
      check($sformatf("v%0d_done_cyc", k), 32'(done_cyc), 32'd15);
    end

    // Timing and address sequencing on the basic vector.
    load_vec(vecs[0]);
    run_layer(1'b0, 1'b0);
    check("busy_at_accept", 32'(busy_at0), 32'd1);
    check("valid_cyc0", 32'(vcyc[0]), 32'd7);
    check("valid_cyc1", 32'(vcyc[1]), 32'd14);
    for (int i = 0; i < IN_SIZE; i++) begin
      check($sformatf("in_addr_n0_%0d", i), 32'(tr_in[i]), 32'(i));
      check($sformatf("in_addr_n1_%0d", i), 32'(tr_in[7+i]), 32'(i));
      check($sformatf("w_addr_n0_%0d", i), 32'(tr_w[i]), 32'(i));
      check($sformatf("w_addr_n1_%0d", i), 32'(tr_w[7+i]), 32'(4+i));
    end
    check("b_addr_n0", 32'(tr_b[2]), 32'd0);
    check("b_addr_n1", 32'(tr_b[9]), 32'd1);
    check("done_one_cycle", 32'(done_after), 32'd0);
    check("busy_after_done", 32'(busy_after), 32'd0);
    check("out_data_holds", 32'(out_data), 32'h0240);

    // sat_flag is sticky past done and clears on the next accept.
    load_vec(vecs[6]);
    run_layer(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("sat_holds_idle", 32'(sat_flag), 32'd1);
    load_vec(vecs[0]);
    run_layer(1'b0, 1'b0);
    check("sat_clear_on_accept", 32'(sat_at0), 32'd0);
    check("sat_clear_end", 32'(sat_flag), 32'd0);

    // start pulses during the run must not restart it or shift done.
    load_vec(vecs[1]);
    run_layer(1'b0, 1'b1);
    check("midstart_done_cyc", 32'(done_cyc), 32'd15);
    check("midstart_nvalid", 32'(n_valid), 32'd2);
    check("midstart_out1", 32'(vdat[1]), 32'h0100);
    repeat (3) @(negedge clk);
    check("midstart_idle", 32'(busy), 32'd0);

    // Reset during neuron 1's MAC aborts the run.
    load_vec(vecs[0]);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("abort_in_neuron1", 32'(b_addr), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_outputs", {29'd0, out_valid, done, sat_flag}, 32'd0);
    check("abort_data", 32'(out_data), 32'd0);
    rst = 1'b1;
    quiet = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || done || busy) quiet++;
    end
    check("abort_quiet", 32'(quiet), 32'd0);

    // A normal run after the abort.
    load_vec(vecs[2]);
    run_layer(1'b0, 1'b0);
    check("post_abort_out0", 32'(vdat[0]), 32'hFE40);
    check("post_abort_done_cyc", 32'(done_cyc), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
